// File: rtl/fq_pkt_fifo.sv
// fq_pkt_fifo
//   Store-and-forward packet FIFO feeding one input lane of the fair-queue
//   arbiter. Ingress words are buffered as they arrive. A packet becomes
//   visible on the read port only after its final word has arrived and its
//   word count matches the length byte in its header. Partial or malformed
//   packets are never exposed to the reader.
//
// Parameters
//   DEPTH_LOG2  buffer depth = 2**DEPTH_LOG2 64-bit words
//   MAX_WORDS   largest accepted packet (header included), 1..min(255, depth)
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   in_valid     ingress word valid
//   in_ready     ingress can accept a word
//   in_data      ingress word; [7:0] of a header word = total word count
//   in_last      final word of a packet
//   fifo_rdreq   pop the head word
//   fifo_empty   no committed word is available
//   fifo_data    show-ahead head word, valid while !fifo_empty
//   pkt_commit   1-cycle pulse: a packet became readable
//   pkt_drop     1-cycle pulse: a packet was discarded
//   dbg_state    write FSM state (0 = HDR, 1 = BODY, 2 = DROP)
//
// Handshake: a word moves on a clock edge where in_valid && in_ready are both
// high. in_valid may be held while in_ready is low; in_data/in_last must stay
// stable until the transfer. fifo_rdreq pops only while !fifo_empty; a request
// while empty has no effect.

module fq_pkt_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int MAX_WORDS  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic        fifo_rdreq,
  output logic        fifo_empty,
  output logic [63:0] fifo_data,
  output logic        pkt_commit,
  output logic        pkt_drop,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      len_q, len_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q;

  logic [63:0]     mem [DEPTH];

  logic [PW-1:0]   used;
  logic [PW-1:0]   wr_next;
  logic            xfer;
  logic            pop;
  logic [7:0]      hdr_len;
  logic            hdr_bad;
  logic [7:0]      cnt_inc;

  // Occupancy counts everything written but not yet popped, partial packets
  // included, so an in-flight packet can never overwrite unread data.
  assign used       = wr_ptr_q - rd_ptr_q;
  assign in_ready   = !rst && (used < PW'(DEPTH));
  assign xfer       = in_valid && in_ready;

  assign fifo_empty = (rd_ptr_q == wr_commit_q);
  assign pop        = fifo_rdreq && !fifo_empty;
  assign fifo_data  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign wr_next    = wr_ptr_q + PW'(1);
  assign hdr_len    = in_data[7:0];
  assign hdr_bad    = (hdr_len == 8'd0) || ({1'b0, hdr_len} > MAX_W9);
  assign cnt_inc    = cnt_q + 8'd1;
  assign dbg_state  = state_q;

  // Next-state logic. A drop rewinds wr_ptr to the last committed position,
  // which frees the partial packet's space immediately.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    pkt_commit  = 1'b0;
    pkt_drop    = 1'b0;

    if (xfer) begin
      unique case (state_q)
        S_HDR: begin
          len_d = hdr_len;
          cnt_d = 8'd1;
          if (hdr_bad) begin
            pkt_drop = 1'b1;
            wr_ptr_d = wr_commit_q;
            state_d  = in_last ? S_HDR : S_DROP;
          end else if (in_last) begin
            if (hdr_len == 8'd1) begin
              pkt_commit  = 1'b1;
              wr_ptr_d    = wr_next;
              wr_commit_d = wr_next;
            end else begin
              pkt_drop = 1'b1;
              wr_ptr_d = wr_commit_q;
            end
          end else if (hdr_len == 8'd1) begin
            // A one-word packet whose header is not marked last is already
            // too long; discard the rest of it.
            pkt_drop = 1'b1;
            wr_ptr_d = wr_commit_q;
            state_d  = S_DROP;
          end else begin
            wr_ptr_d = wr_next;
            state_d  = S_BODY;
          end
        end

        S_BODY: begin
          cnt_d = cnt_inc;
          if (in_last) begin
            state_d = S_HDR;
            if (cnt_inc == len_q) begin
              pkt_commit  = 1'b1;
              wr_ptr_d    = wr_next;
              wr_commit_d = wr_next;
            end else begin
              pkt_drop = 1'b1;
              wr_ptr_d = wr_commit_q;
            end
          end else if (cnt_inc == len_q) begin
            // Length reached without in_last: packet is too long.
            pkt_drop = 1'b1;
            wr_ptr_d = wr_commit_q;
            state_d  = S_DROP;
          end else begin
            wr_ptr_d = wr_next;
          end
        end

        S_DROP: begin
          if (in_last) state_d = S_HDR;
        end

        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage is not reset. Words arriving while discarding are not written.
  always_ff @(posedge clk) begin
    if (xfer && (state_q != S_DROP)) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

endmodule
